// File: rtl/divider_recombine_pkg.sv
// Shared constants for the divider recombine stage.
//   - FSM state encodings (IDLE / RUN / HOLD)
//   - default operand width and the derived result width
package divider_recombine_pkg;

  localparam int WIDTH_DEF  = 4;
  localparam int RWIDTH_DEF = 2 * WIDTH_DEF;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

endpackage

// File: rtl/divider_recombine_step.sv
// One shift-and-add multiplier step (purely combinational).
// Ports:
//   acc, mcand, mplier           : current accumulator / multiplicand / multiplier
//   acc_nxt, mcand_nxt, mplier_nxt: values after consuming mplier[0]
module divider_recombine_step #(
  parameter int WIDTH  = 4,
  parameter int RWIDTH = 2 * WIDTH
) (
  input  logic [RWIDTH-1:0] acc,
  input  logic [RWIDTH-1:0] mcand,
  input  logic [WIDTH-1:0]  mplier,
  output logic [RWIDTH-1:0] acc_nxt,
  output logic [RWIDTH-1:0] mcand_nxt,
  output logic [WIDTH-1:0]  mplier_nxt
);

  // Sum cannot overflow RWIDTH: the largest reachable value is
  // (2^W-1)^2 + (2^W-1) < 2^(2W), so the carry-out is dropped.
  assign acc_nxt    = mplier[0] ? (acc + mcand) : acc;
  assign mcand_nxt  = mcand << 1;
  assign mplier_nxt = mplier >> 1;

endmodule

// File: rtl/divider_recombine_seq.sv
// Reconstructs dividend = quotient*divisor + remainder, one multiplier bit
// per cycle, as the inverse/self-check stage behind the 4-bit divider.
// Ports:
//   clk, rst_n              : clock, async active-low reset
//   in_valid / in_ready     : operand handshake (ready only in IDLE)
//   quotient, divisor,
//   remainder               : operand triple, captured on acceptance
//   out_valid / out_ready   : result handshake (valid only in HOLD)
//   dividend                : last completed result (qualify with out_valid)
//   err                     : consistency flag, only meaningful in HOLD
// Build option: DIVIDER_RECOMBINE_CHECK_EN enables the err compare logic;
// without it err is tied low.
module divider_recombine_seq
  import divider_recombine_pkg::*;
#(
  parameter int WIDTH  = WIDTH_DEF,
  parameter int RWIDTH = 2 * WIDTH
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WIDTH-1:0]  quotient,
  input  logic [WIDTH-1:0]  divisor,
  input  logic [WIDTH-1:0]  remainder,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [RWIDTH-1:0] dividend,
  output logic              err
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  logic [1:0]        state;
  logic [RWIDTH-1:0] acc, mcand;
  logic [WIDTH-1:0]  mplier;
  logic [CW-1:0]     count;

  logic [RWIDTH-1:0] acc_nxt, mcand_nxt;
  logic [WIDTH-1:0]  mplier_nxt;

  divider_recombine_step #(.WIDTH(WIDTH), .RWIDTH(RWIDTH)) u_step (
    .acc        (acc),
    .mcand      (mcand),
    .mplier     (mplier),
    .acc_nxt    (acc_nxt),
    .mcand_nxt  (mcand_nxt),
    .mplier_nxt (mplier_nxt)
  );

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == HOLD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      mcand    <= '0;
      mplier   <= '0;
      count    <= '0;
      dividend <= '0;
    end else begin
      case (state)
        IDLE: if (in_valid) begin
          acc    <= RWIDTH'(remainder);
          mcand  <= RWIDTH'(divisor);
          mplier <= quotient;
          count  <= '0;
          state  <= RUN;
        end
        RUN: begin
          acc    <= acc_nxt;
          mcand  <= mcand_nxt;
          mplier <= mplier_nxt;
          count  <= count + 1'b1;
          // Always WIDTH steps, even when mplier is already zero, so
          // latency is fixed regardless of operands.
          if (count == LAST) begin
            dividend <= acc_nxt;
            state    <= HOLD;
          end
        end
        HOLD: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DIVIDER_RECOMBINE_CHECK_EN
  // A legal divider output never has divisor==0 or remainder>=divisor.
  logic err_pending;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_pending <= 1'b0;
    else if (state == IDLE && in_valid)
      err_pending <= (divisor == '0) || (remainder >= divisor);
  end

  assign err = (state == HOLD) && err_pending;
`else
  assign err = 1'b0;
`endif

endmodule
